// File: rtl/ctrl_pipeline.sv
// Control pipeline: ID/EX, EX/MEM, MEM/WB control registers, hazard stall/flush and syscall drain FSM.
// Optional macro FWD_EN adds fwd_a/fwd_b operand-forwarding selects and narrows the hazard check to load-use.
module ctrl_pipeline #(
    parameter int LINK_REG = 31,
    parameter int REG_W    = 5
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             id_valid,
    input  logic             id_regDst,
    input  logic             id_jump,
    input  logic             id_branch,
    input  logic             id_memRead,
    input  logic             id_memToReg,
    input  logic             id_regWrite,
    input  logic             id_ALUSrc,
    input  logic             id_memWrite,
    input  logic             id_sys,
    input  logic             id_jr,
    input  logic             id_jal,
    input  logic [2:0]       id_ALUop,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             branch_taken,
    input  logic             sys_ack,
    output logic             stall,
    output logic             flush_ifid,
    output logic [2:0]       ex_ALUop,
    output logic             ex_ALUSrc,
    output logic             ex_branch,
    output logic             ex_memRead,
    output logic             ex_memWrite,
    output logic             ex_jal,
    output logic [REG_W-1:0] ex_dest,
    output logic             mem_memRead,
    output logic             mem_memWrite,
    output logic             mem_regWrite,
    output logic             mem_memToReg,
    output logic [REG_W-1:0] mem_dest,
    output logic             wb_regWrite,
    output logic             wb_memToReg,
    output logic [REG_W-1:0] wb_dest,
    output logic             sys_req,
`ifdef FWD_EN
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
`endif
    output logic [1:0]       dbg_state
);

    localparam logic [REG_W-1:0] LINK_DEST = REG_W'(LINK_REG);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ID/EX
    logic [2:0]       r_ex_ALUop;
    logic             r_ex_ALUSrc;
    logic             r_ex_branch;
    logic             r_ex_memRead;
    logic             r_ex_memWrite;
    logic             r_ex_jal;
    logic             r_ex_regWrite;
    logic             r_ex_memToReg;
    logic             r_ex_sys;
    logic [REG_W-1:0] r_ex_dest;
`ifdef FWD_EN
    logic [REG_W-1:0] r_ex_rs;
    logic [REG_W-1:0] r_ex_rt;
`endif

    // EX/MEM
    logic             r_mem_memRead;
    logic             r_mem_memWrite;
    logic             r_mem_regWrite;
    logic             r_mem_memToReg;
    logic             r_mem_sys;
    logic [REG_W-1:0] r_mem_dest;

    // MEM/WB
    logic             r_wb_regWrite;
    logic             r_wb_memToReg;
    logic [REG_W-1:0] r_wb_dest;

    logic             w_busy;
    logic             w_rt_used;
    logic             w_ex_hit;
    logic             w_mem_hit;
    logic             w_hazard;
    logic             w_stall_core;
    logic             w_is_jump;
    logic             w_issue;
    logic             w_sys_accept;
    logic [REG_W-1:0] w_id_dest;
    logic             w_id_regWrite;

    assign w_id_dest     = id_jal ? LINK_DEST : (id_regDst ? id_rd : id_rt);
    assign w_id_regWrite = (id_regWrite | id_jal) & (w_id_dest != '0);

    assign w_rt_used = !id_ALUSrc | id_memWrite | id_branch;
    assign w_ex_hit  = (r_ex_dest != '0) &
                       ((r_ex_dest == id_rs) | (w_rt_used & (r_ex_dest == id_rt)));
    assign w_mem_hit = (r_mem_dest != '0) &
                       ((r_mem_dest == id_rs) | (w_rt_used & (r_mem_dest == id_rt)));

`ifdef FWD_EN
    assign w_hazard = id_valid & r_ex_memRead & w_ex_hit;
`else
    // Without forwarding every in-flight writer in EX or MEM blocks a dependent reader.
    assign w_hazard = id_valid &
                      ((w_ex_hit & (r_ex_memRead | r_ex_regWrite)) |
                       (w_mem_hit & r_mem_regWrite));
`endif

    assign w_busy       = (r_state != S_RUN);
    assign w_stall_core = w_busy | (w_hazard & !branch_taken);
    assign w_is_jump    = id_jump | id_jal | id_jr;
    assign w_issue      = id_valid & !branch_taken & !w_stall_core;
    assign w_sys_accept = w_issue & id_sys;

    // Front-end controls are gated by reset so they read 0 while rst_b is low.
    assign stall      = rst_b & w_stall_core;
    assign flush_ifid = rst_b & (branch_taken | (id_valid & w_is_jump & !w_stall_core));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (w_sys_accept) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_mem_sys)    w_state_nxt = S_WAIT;
            S_WAIT:  if (sys_ack)      w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_ex_ALUop     <= '0;
            r_ex_ALUSrc    <= 1'b0;
            r_ex_branch    <= 1'b0;
            r_ex_memRead   <= 1'b0;
            r_ex_memWrite  <= 1'b0;
            r_ex_jal       <= 1'b0;
            r_ex_regWrite  <= 1'b0;
            r_ex_memToReg  <= 1'b0;
            r_ex_sys       <= 1'b0;
            r_ex_dest      <= '0;
`ifdef FWD_EN
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
`endif
            r_mem_memRead  <= 1'b0;
            r_mem_memWrite <= 1'b0;
            r_mem_regWrite <= 1'b0;
            r_mem_memToReg <= 1'b0;
            r_mem_sys      <= 1'b0;
            r_mem_dest     <= '0;
            r_wb_regWrite  <= 1'b0;
            r_wb_memToReg  <= 1'b0;
            r_wb_dest      <= '0;
        end else begin
            if (w_issue) begin
                r_ex_ALUop    <= id_ALUop;
                r_ex_ALUSrc   <= id_ALUSrc;
                r_ex_branch   <= id_branch;
                r_ex_memRead  <= id_memRead;
                r_ex_memWrite <= id_memWrite;
                r_ex_jal      <= id_jal;
                r_ex_regWrite <= w_id_regWrite;
                r_ex_memToReg <= id_memToReg;
                r_ex_sys      <= id_sys;
                r_ex_dest     <= w_id_dest;
`ifdef FWD_EN
                r_ex_rs       <= id_rs;
                r_ex_rt       <= id_rt;
`endif
            end else begin
                r_ex_ALUop    <= '0;
                r_ex_ALUSrc   <= 1'b0;
                r_ex_branch   <= 1'b0;
                r_ex_memRead  <= 1'b0;
                r_ex_memWrite <= 1'b0;
                r_ex_jal      <= 1'b0;
                r_ex_regWrite <= 1'b0;
                r_ex_memToReg <= 1'b0;
                r_ex_sys      <= 1'b0;
                r_ex_dest     <= '0;
`ifdef FWD_EN
                r_ex_rs       <= '0;
                r_ex_rt       <= '0;
`endif
            end
            // Back end never stalls; only PC and IF/ID hold.
            r_mem_memRead  <= r_ex_memRead;
            r_mem_memWrite <= r_ex_memWrite;
            r_mem_regWrite <= r_ex_regWrite;
            r_mem_memToReg <= r_ex_memToReg;
            r_mem_sys      <= r_ex_sys;
            r_mem_dest     <= r_ex_dest;
            r_wb_regWrite  <= r_mem_regWrite;
            r_wb_memToReg  <= r_mem_memToReg;
            r_wb_dest      <= r_mem_dest;
        end
    end

`ifdef FWD_EN
    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (r_mem_regWrite && (r_mem_dest != '0) && (r_mem_dest == r_ex_rs)) begin
            fwd_a = 2'd2;
        end else if (r_wb_regWrite && (r_wb_dest != '0) && (r_wb_dest == r_ex_rs)) begin
            fwd_a = 2'd1;
        end
        if (r_mem_regWrite && (r_mem_dest != '0) && (r_mem_dest == r_ex_rt)) begin
            fwd_b = 2'd2;
        end else if (r_wb_regWrite && (r_wb_dest != '0) && (r_wb_dest == r_ex_rt)) begin
            fwd_b = 2'd1;
        end
    end
`endif

    assign ex_ALUop     = r_ex_ALUop;
    assign ex_ALUSrc    = r_ex_ALUSrc;
    assign ex_branch    = r_ex_branch;
    assign ex_memRead   = r_ex_memRead;
    assign ex_memWrite  = r_ex_memWrite;
    assign ex_jal       = r_ex_jal;
    assign ex_dest      = r_ex_dest;
    assign mem_memRead  = r_mem_memRead;
    assign mem_memWrite = r_mem_memWrite;
    assign mem_regWrite = r_mem_regWrite;
    assign mem_memToReg = r_mem_memToReg;
    assign mem_dest     = r_mem_dest;
    assign wb_regWrite  = r_wb_regWrite;
    assign wb_memToReg  = r_wb_memToReg;
    assign wb_dest      = r_wb_dest;
    assign sys_req      = (r_state == S_WAIT);
    assign dbg_state    = r_state;

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
Consumes the decoded control word produced each cycle by the ID-stage control decoder. Carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers, resolves the write-destination register, and detects load-use hazards. Generates stall and flush for the front end and runs the syscall drain/handshake FSM. Sits between the control decoder and the EX/MEM/WB datapath.

Parameters:
LINK_REG, 31, destination register forced for jal
REG_W, 5, register-index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_b  in  1  synchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_regDst, id_jump, id_branch, id_memRead, id_memToReg, id_regWrite, id_ALUSrc, id_memWrite, id_sys, id_jr, id_jal  in  1 each  decoder outputs
id_ALUop  in  3  decoder ALU operation
id_rs, id_rt, id_rd  in  REG_W  instruction register fields
branch_taken  in  1  EX-stage branch resolved taken
sys_ack  in  1  syscall service complete
stall  out  1  hold PC and IF/ID
flush_ifid  out  1  convert IF/ID to bubble
ex_ALUop  out  3  registered control in EX
ex_ALUSrc, ex_branch, ex_memRead, ex_memWrite, ex_jal  out  1 each  registered control in EX
ex_dest  out  REG_W  registered destination in EX
mem_memRead, mem_memWrite, mem_regWrite, mem_memToReg  out  1 each  registered control in MEM
mem_dest  out  REG_W  registered destination in MEM
wb_regWrite, wb_memToReg  out  1 each  registered control in WB
wb_dest  out  REG_W  registered destination in WB
sys_req  out  1  syscall at WB, awaiting service

Behaviour:
- Reset (rst_b=0 at edge): all ex_/mem_/wb_ outputs 0, dests 0, sys_req 0, FSM=RUN. stall and flush_ifid are combinational, so they are 0 while in reset.
- Dest: jal -> LINK_REG; else regDst ? rd : rt. jal forces regWrite=1. Dest 0 forces regWrite=0.
- Bubble: all control bits 0, dest 0. Inserted whenever id_valid=0.
- Latency: one cycle per stage. An ID control word appears on ex_ the next cycle, mem_ +2, wb_ +3.
- rt_used = !id_ALUSrc | id_memWrite | id_branch.
- Load-use: ex_memRead & ex_dest!=0 & id_valid & (ex_dest==id_rs | (rt_used & ex_dest==id_rt)). Response: stall=1 and a bubble into ID/EX.
- jump/jal/jr in ID with id_valid: flush_ifid=1 that cycle. No stall.
- branch_taken: flush_ifid=1, bubble into ID/EX, stall=0. This has priority over load-use and over the jump flush.
- FSM RUN: id_sys&id_valid&!stall&!branch_taken -> DRAIN, and the syscall enters EX.
- FSM DRAIN: stall=1, ID/EX gets bubbles. When the syscall reaches MEM/WB -> WAIT with sys_req=1.
- FSM WAIT: stall=1 and sys_req held until sys_ack. sys_ack -> RUN, sys_req=0 next cycle. sys_ack outside WAIT is ignored.
- Syscall tracking: a sys bit rides the pipeline internally. Total stall from syscall in ID: 3 cycles plus the ack wait.
- EX/MEM and MEM/WB always advance; only IF/ID and PC stall.
- Reset mid-DRAIN/WAIT: returns to RUN, drops sys_req, clears all stages.

Optional Feature:
FWD_EN: adds outputs fwd_a, fwd_b (2 bits each).
- Encoding: 2=EX/MEM, 1=MEM/WB, 0=regfile. Selection is for the EX operands rs/rt, matched against mem_dest/wb_dest with regWrite and dest!=0. EX/MEM wins over MEM/WB.
- Required EX-stage source indices are registered internally.
- Without FWD_EN: no fwd ports. The hazard condition widens to any ex_ or mem_ stage with regWrite&dest!=0 matching id_rs or used id_rt, and produces the same stall/bubble.

Test Plan:
- lw $8 then add $9,$8,$1 back-to-back -> stall=1 one cycle, ex_ controls all 0 that cycle, add reaches EX next cycle. With FWD_EN: fwd_a=1 on the add.
- beq in EX, branch_taken=1 while lw-use hazard present in ID -> flush_ifid=1, stall=0, ex_ bubble.
- jal in ID -> flush_ifid=1 same cycle; 3 cycles later wb_regWrite=1, wb_dest=31.
- addi $0,$3,5 -> wb_regWrite=0 at WB.
- syscall in ID -> stall=1 from next cycle; sys_req=1 once it reaches MEM/WB; sys_ack held 4 cycles later -> sys_req=0 and stall=0 the following cycle.
- rst_b=0 for one cycle during WAIT -> next cycle sys_req=0, stall=0, all pipeline outputs 0.
